// File: rtl/ll_sc_pkg.sv
// Shared constants, reservation record and helpers for the LL/SC reservation block.
package ll_sc_pkg;

  localparam int unsigned DEF_BITS      = 32;
  localparam int unsigned DEF_GRAN_BITS = 2;
  localparam int unsigned DEF_TIMEOUT   = 255;

  // Granule addresses are held zero-extended to a fixed width so the record is parameter independent.
  localparam int unsigned GA_MAX_W = 64;
  localparam int unsigned TIMER_W  = 16;

  typedef struct packed {
    logic                valid;
    logic [GA_MAX_W-1:0] ga;
    logic [TIMER_W-1:0]  timer;
  } resv_t;

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ll_sc_entry.sv
// One channel's reservation: state, granule match and optional lifetime timer.
// Optional feature: LL_SC_LINK_TIMEOUT_EN enables reservation expiry.
module ll_sc_entry
  import ll_sc_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ll,
  input  logic                sc,
  input  logic                snoop_clr,
  input  logic [GA_MAX_W-1:0] gran,
  output logic                valid,
  output logic [GA_MAX_W-1:0] ga,
  output logic                hit_c
);

  resv_t r;
  resv_t r_nx;
  logic  live_c;

  // Next reservation: LL wins over SC/snoop clears (snoop is ordered before a same-cycle LL).
  always_comb begin
    r_nx = r;
    if (ll) begin
      r_nx.valid = 1'b1;
      r_nx.ga    = gran;
      r_nx.timer = TIMER_W'(TIMEOUT);
    end else if (sc || snoop_clr) begin
      r_nx.valid = 1'b0;
`ifdef LL_SC_LINK_TIMEOUT_EN
    end else if (r.valid) begin
      if (r.timer == '0) begin
        r_nx.valid = 1'b0;
      end else begin
        r_nx.timer = r.timer - 1'b1;
      end
`endif
    end
  end

  // Reservation register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else begin
      r <= r_nx;
    end
  end

`ifdef LL_SC_LINK_TIMEOUT_EN
  // An expired reservation still reads valid for one cycle but can no longer succeed.
  assign live_c = (r.timer != '0);
`else
  // Timer is loaded but inert when expiry is not built in.
  logic unused_timer;
  assign unused_timer = ^r.timer;
  assign live_c = 1'b1;
`endif

  assign hit_c = r.valid & live_c & (r.ga == gran);
  assign valid = r.valid;
  assign ga    = r.ga;

endmodule

// File: rtl/ll_sc_resv.sv
// LL/SC reservation tracker: per-channel links, SC arbitration, store snooping, fail counter.
// Optional feature: define LL_SC_LINK_TIMEOUT_EN for reservation lifetime expiry.
module ll_sc_resv
  import ll_sc_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int CHANNELS  = 2,
  parameter int GRAN_BITS = DEF_GRAN_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      ll_req,
  input  logic [CHANNELS-1:0]      sc_req,
  input  logic [CHANNELS-1:0]      st_req,
  input  logic [CHANNELS*BITS-1:0] addr,
  output logic [CHANNELS-1:0]      sc_ok,
  output logic [CHANNELS-1:0]      mem_wr,
  output logic [CHANNELS-1:0]      link_valid,
  output logic [15:0]              sc_fail_cnt
);

  logic [GA_MAX_W-1:0] gran [CHANNELS];
  logic [GA_MAX_W-1:0] ga_q [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] ll_eff;
  logic [CHANNELS-1:0] st_eff;
  logic [CHANNELS-1:0] sc_ok_v;
  logic [CHANNELS-1:0] snoop_clr;
  logic [CHANNELS-1:0] sc_fail;
  logic [3:0]          n_fail;
  logic [16:0]         cnt_sum;
  logic                win;

  // Per-channel priority: SC over LL over plain store.
  assign ll_eff = ll_req & ~sc_req;
  assign st_eff = st_req & ~sc_req & ~ll_req;

  // Granule extraction and one reservation entry per channel.
  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    assign gran[g] = GA_MAX_W'(addr[g*BITS+GRAN_BITS +: BITS-GRAN_BITS]);

    ll_sc_entry #(
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .ll        (ll_eff[g]),
      .sc        (sc_req[g]),
      .snoop_clr (snoop_clr[g]),
      .gran      (gran[g]),
      .valid     (link_valid[g]),
      .ga        (ga_q[g]),
      .hit_c     (hit[g])
    );
  end

  // SC arbitration: lowest-index winner per granule, nothing succeeds during reset.
  always_comb begin
    sc_ok_v = '0;
    win     = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      win = ~rst & sc_req[c] & hit[c];
      for (int i = 0; i < c; i++) begin
        if (sc_ok_v[i] && (gran[i] == gran[c])) begin
          win = 1'b0;
        end
      end
      sc_ok_v[c] = win;
    end
  end

  assign sc_ok  = sc_ok_v;
  assign mem_wr = rst ? '0 : (st_eff | sc_ok_v);

  // Snoop fan-out: any write to a reserved granule kills that reservation next cycle.
  always_comb begin
    snoop_clr = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (mem_wr[k] && link_valid[j] && (ga_q[j] == gran[k])) begin
          snoop_clr[j] = 1'b1;
        end
      end
    end
  end

  // Failed-SC tally for this cycle and saturating sum.
  assign sc_fail = rst ? '0 : (sc_req & ~sc_ok_v);
  assign n_fail  = count_ones(8'(sc_fail));
  assign cnt_sum = {1'b0, sc_fail_cnt} + 17'(n_fail);

  // Saturating failed-SC counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_fail_cnt <= 16'd0;
    end else if (cnt_sum[16]) begin
      sc_fail_cnt <= 16'hFFFF;
    end else begin
      sc_fail_cnt <= cnt_sum[15:0];
    end
  end

endmodule

// File: doc/ll_sc_resv.md
LL_SC_RESV -- requirements
Module: ll_sc_resv

Interface
REQ-001 SHALL take parameter BITS, 32, address width.
REQ-002 SHALL take parameter CHANNELS, 2, number of requesting ports (harts/pipes), range 1..8.
REQ-003 SHALL take parameter GRAN_BITS, 2, low address bits ignored in compares (word granule).
REQ-004 SHALL take parameter TIMEOUT, 255, reservation lifetime in cycles (used only under LINK_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  system clock; one clock only.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ll_req  input  CHANNELS  per-channel load-linked strobe.
REQ-008 SHALL have port sc_req  input  CHANNELS  per-channel store-conditional strobe.
REQ-009 SHALL have port st_req  input  CHANNELS  per-channel plain store strobe.
REQ-010 SHALL have port addr  input  CHANNELS x BITS  per-channel access address.
REQ-011 SHALL have port sc_ok  output  CHANNELS  combinational SC success, same cycle as sc_req; feeds atomic write-back of 1/0.
REQ-012 SHALL have port mem_wr  output  CHANNELS  combinational data-memory write enable: st_req | sc_ok.
REQ-013 SHALL have port link_valid  output  CHANNELS  registered reservation-valid flags.
REQ-014 SHALL have port sc_fail_cnt  output  16  registered saturating count of failed SCs, all channels.

Function
REQ-015 SHALL hold per channel c: valid[c], granule address ga[c] = addr[BITS-1:GRAN_BITS].
REQ-016 SHALL, per channel per cycle, honour priority sc_req > ll_req > st_req; lower-priority strobes in the same cycle ignored.
REQ-017 SHALL on ll_req[c]: next cycle valid[c]=1, ga[c]=granule of addr[c] (re-LL overwrites).
REQ-018 SHALL set sc_ok[c]=1 iff sc_req[c], valid[c], ga[c] equals granule of addr[c], and no lower-index channel has sc_ok in the same cycle to the same granule.
REQ-019 SHALL clear valid[c] next cycle after any sc_req[c], success or fail.
REQ-020 SHALL treat every mem_wr[k] granule G as a snoop: next cycle clear valid[j] for all j with valid[j] and ga[j]==G, including j==k.
REQ-021 SHALL, when ll_req[j] and a snoop to the same granule coincide, order the snoop first: reservation j ends valid.
REQ-022 SHALL increment sc_fail_cnt by the number of failing SCs per cycle, saturating at 16'hFFFF.
REQ-023 SHALL, with all strobes low, hold all state (no decay unless LINK_TIMEOUT_EN).

Reset
REQ-024 SHALL, while rst is high at a clk edge, set valid=0, ga=0, timers=0, sc_fail_cnt=0; strobes in that cycle ignored; sc_ok and mem_wr forced 0 while rst high.
REQ-025 SHALL resume normal operation the first edge after rst falls; reset mid-sequence loses all reservations.

Configuration
REQ-026 SHALL support macro LL_SC_LINK_TIMEOUT_EN: when defined, each channel loads an 8..16-bit down-counter with TIMEOUT on LL, decrements while valid, clears valid the cycle after reaching 0; SC on the expiry cycle fails.
REQ-027 SHALL, without LL_SC_LINK_TIMEOUT_EN, have no timers; reservations persist until SC, snoop or reset.

Structure
REQ-028 SHALL place in package ll_sc_pkg: default BITS/GRAN_BITS/TIMEOUT constants, typedef resv_t {valid, ga, timer}.
REQ-029 SHALL instantiate one sub-module ll_sc_entry per channel (state, match, timer); arbitration, snoop fan-out and counter in ll_sc_resv.

Verification
REQ-030 SHALL cover: ch0 LL 0x100, then SC 0x100 -> sc_ok[0]=1, mem_wr[0]=1, link_valid[0]=0 next cycle.
REQ-031 SHALL cover: ch0 LL 0x100, ch1 st 0x102 (same granule), ch0 SC 0x100 -> sc_ok[0]=0, sc_fail_cnt=1.
REQ-032 SHALL cover: ch0 and ch1 LL 0x200, both SC 0x200 same cycle -> sc_ok=2'b01, ch1 fails, both valid cleared.
REQ-033 SHALL cover: ch1 LL 0x300 same cycle as ch0 st 0x300 -> link_valid[1]=1; later ch1 SC 0x300 succeeds.
REQ-034 SHALL cover: with LL_SC_LINK_TIMEOUT_EN, TIMEOUT=4, LL 0x40 then SC after 6 idle cycles -> sc_ok=0; SC after 2 -> 1.
REQ-035 SHALL cover: rst asserted one cycle after LL 0x80 -> link_valid=0, SC 0x80 fails, sc_fail_cnt counts from 0.
